instr_encoder_loader: RTL and testbench

- Packs decoded instruction fields (opcode, register numbers, immediate, branch/jump offset) into 32-bit instruction words.
- Writes the words sequentially into instruction memory over the memory write/busywait interface.
- Field placement is the exact inverse of the CPU's instruction decode; the block is used to program instruction memory before or between runs.

---
 rtl/instr_encoder_loader.sv | 151 +++++++++++++++
 tb/tb_instr_encoder_loader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - packs decoded instruction fields into words and writes them to instruction memory
module instr_encoder_loader #(
    parameter int          ADDR_W     = 10,
    parameter int          BASE_ADDR  = 0,
    parameter int          MAX_INSTR  = 256,
    parameter logic [7:0]  MAX_OPCODE = 8'd20
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [7:0]        IN_OPCODE,
    input  logic [2:0]        IN_WRITEREG,
    input  logic [2:0]        IN_READREG1,
    input  logic [2:0]        IN_READREG2,
    input  logic [7:0]        IN_IMMEDIATE,
    input  logic              IN_USE_IMM,
    input  logic [7:0]        IN_OFFSET,
    input  logic              IN_LAST,
    output logic              MEM_WRITE,
    output logic [ADDR_W-1:0] MEM_ADDRESS,
    output logic [31:0]       MEM_WRITEDATA,
    input  logic              MEM_BUSYWAIT,
    output logic              ILLEGAL,
    output logic              FULL,
    output logic              DONE,
    output logic [ADDR_W-1:0] INSTR_COUNT
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_FINISH
    } state_t;

    localparam logic [7:0]        OP_JUMP   = 8'd6;
    localparam logic [7:0]        OP_BEQ    = 8'd7;
    localparam logic [7:0]        OP_BNE    = 8'd12;
    localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);
    localparam logic [ADDR_W:0]   MAX_CNT   = (ADDR_W+1)'(MAX_INSTR);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   count_q, count_d;
    logic [31:0]         word_q, word_d;
    logic                last_q, last_d;
    logic                full_q, full_d;
    logic                illegal_q, illegal_d;

    logic [31:0]         enc_word;
    logic [ADDR_W:0]     count_inc;
    logic                in_ready;

    // Field placement mirrors the CPU decoder; unused bits stay zero.
    always_comb begin
        enc_word        = '0;
        enc_word[31:24] = IN_OPCODE;
        if (IN_OPCODE == OP_JUMP) begin
            enc_word[23:16] = IN_OFFSET;
        end else if ((IN_OPCODE == OP_BEQ) || (IN_OPCODE == OP_BNE)) begin
            enc_word[23:16] = IN_OFFSET;
            enc_word[10:8]  = IN_READREG1;
            enc_word[2:0]   = IN_READREG2;
        end else begin
            enc_word[18:16] = IN_WRITEREG;
            enc_word[10:8]  = IN_READREG1;
            if (IN_USE_IMM) begin
                enc_word[7:0] = IN_IMMEDIATE;
            end else begin
                enc_word[2:0] = IN_READREG2;
            end
        end
    end

    assign count_inc = {1'b0, count_q} + (ADDR_W+1)'(1);
    assign in_ready  = (state_q == S_IDLE) && !full_q;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        count_d   = count_q;
        word_d    = word_q;
        last_d    = last_q;
        full_d    = full_q;
        illegal_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (IN_VALID && in_ready) begin
                    if (IN_OPCODE > MAX_OPCODE) begin
                        illegal_d = 1'b1;
                    end else begin
                        word_d  = enc_word;
                        last_d  = IN_LAST;
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (!MEM_BUSYWAIT) begin
                    addr_d  = addr_q + ADDR_STEP;
                    count_d = count_inc[ADDR_W-1:0];
                    if (last_q) begin
                        state_d = S_FINISH;
                    end else begin
                        full_d  = (count_inc == MAX_CNT);
                        state_d = S_IDLE;
                    end
                end
            end
            S_FINISH: begin
                addr_d  = BASE_A;
                count_d = '0;
                full_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= S_IDLE;
            addr_q    <= BASE_A;
            count_q   <= '0;
            word_q    <= '0;
            last_q    <= 1'b0;
            full_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            count_q   <= count_d;
            word_q    <= word_d;
            last_q    <= last_d;
            full_q    <= full_d;
            illegal_q <= illegal_d;
        end
    end

    // MEM_WRITE decodes straight from state so an async reset drops it at once.
    assign IN_READY      = in_ready;
    assign MEM_WRITE     = (state_q == S_WRITE);
    assign MEM_ADDRESS   = addr_q;
    assign MEM_WRITEDATA = word_q;
    assign ILLEGAL       = illegal_q;
    assign FULL          = full_q;
    assign DONE          = (state_q == S_FINISH);
    assign INSTR_COUNT   = count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb/tb_instr_encoder_loader.sv - randomized bench with behavioural model for instr_encoder_loader
module tb_instr_encoder_loader;

    localparam int AW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, in_valid, in_ready, use_imm, last, mem_write, busy, illegal, full, done;
    logic [7:0]    op, imm, off;
    logic [2:0]    wr, r1, r2;
    logic [AW-1:0] mem_addr, count;
    logic [31:0]   mem_wdata;

    logic          rst_b, valid_b, ready_b, use_b, last_b, mw_b, busy_b, ill_b, full_b, done_b;
    logic [7:0]    op_b, imm_b, off_b;
    logic [2:0]    wr_b, r1_b, r2_b;
    logic [AW-1:0] addr_b, count_b;
    logic [31:0]   wd_b;

    instr_encoder_loader #(.ADDR_W(AW)) dut_a (
        .CLK(clk), .RESET_N(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready),
        .IN_OPCODE(op), .IN_WRITEREG(wr), .IN_READREG1(r1), .IN_READREG2(r2),
        .IN_IMMEDIATE(imm), .IN_USE_IMM(use_imm), .IN_OFFSET(off), .IN_LAST(last),
        .MEM_WRITE(mem_write), .MEM_ADDRESS(mem_addr), .MEM_WRITEDATA(mem_wdata),
        .MEM_BUSYWAIT(busy), .ILLEGAL(illegal), .FULL(full), .DONE(done), .INSTR_COUNT(count)
    );

    instr_encoder_loader #(.ADDR_W(AW), .MAX_INSTR(2)) dut_b (
        .CLK(clk), .RESET_N(rst_b), .IN_VALID(valid_b), .IN_READY(ready_b),
        .IN_OPCODE(op_b), .IN_WRITEREG(wr_b), .IN_READREG1(r1_b), .IN_READREG2(r2_b),
        .IN_IMMEDIATE(imm_b), .IN_USE_IMM(use_b), .IN_OFFSET(off_b), .IN_LAST(last_b),
        .MEM_WRITE(mw_b), .MEM_ADDRESS(addr_b), .MEM_WRITEDATA(wd_b),
        .MEM_BUSYWAIT(busy_b), .ILLEGAL(ill_b), .FULL(full_b), .DONE(done_b), .INSTR_COUNT(count_b)
    );

    int total  = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    task automatic timeout_fail(input string name);
        total++;
        $display("FAIL %s: bound expired, required handshake", name);
    endtask

    function automatic logic [31:0] enc(input logic [7:0] o, input logic [2:0] w, input logic [2:0] a,
                                        input logic [2:0] b, input logic [7:0] im, input logic ui,
                                        input logic [7:0] of);
        int v;
        v = int'(o) * 32'h0100_0000;
        if (o == 8'd6) v += int'(of) * 65536;
        else if (o == 8'd7 || o == 8'd12) v += int'(of) * 65536 + int'(a) * 256 + int'(b);
        else v += int'(w) * 65536 + int'(a) * 256 + (ui ? int'(im) : int'(b));
        return 32'(v);
    endfunction

    // Transaction-level reference state
    typedef struct { int a; logic [31:0] d; } wr_t;
    wr_t         wlog[$];
    bit          model_on = 0;
    int          m_addr = 0, m_count = 0;
    bit          m_full = 0, m_done = 0, m_illegal = 0, m_pend = 0, m_last = 0;
    logic [31:0] m_data = 32'h0;
    int          ill_cnt = 0, wcyc = 0;
    int          force_busy = 0;

    always @(posedge clk) begin
        #1;
        if (force_busy > 0) begin
            busy = 1'b1;
            force_busy--;
        end else begin
            busy = ($urandom_range(0, 2) == 0);
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            chk("mem_write", 32'(mem_write), 32'(m_pend));
            chk("in_ready",  32'(in_ready),  32'(!m_pend && !m_done && !m_full));
            chk("done",      32'(done),      32'(m_done));
            chk("illegal",   32'(illegal),   32'(m_illegal));
            chk("full",      32'(full),      32'(m_full));
            chk("count",     32'(count),     32'(m_count));
            chk("addr",      32'(mem_addr),  32'(m_addr));
            chk("wdata",     mem_wdata,      m_data);
            if (illegal) ill_cnt++;
            if (mem_write) wcyc++;
            m_illegal = 0;
            if (m_done) begin
                m_done = 0; m_addr = 0; m_count = 0; m_full = 0;
            end else if (m_pend) begin
                if (!busy) begin
                    wlog.push_back('{m_addr, m_data});
                    m_pend  = 0;
                    m_addr  = (m_addr + 4) % 1024;
                    m_count = m_count + 1;
                    if (m_last) m_done = 1;
                    else if (m_count == 256) m_full = 1;
                end
            end else if (in_valid && !m_full) begin
                if (op > 8'd20) m_illegal = 1;
                else begin
                    m_pend = 1;
                    m_data = enc(op, wr, r1, r2, imm, use_imm, off);
                    m_last = last;
                end
            end
        end
    end

    task automatic send_a(input logic [7:0] o, input logic [2:0] w, input logic [2:0] a, input logic [2:0] b,
                          input logic [7:0] im, input logic ui, input logic [7:0] of, input logic l);
        bit ok;
        @(posedge clk); #1;
        op = o; wr = w; r1 = a; r2 = b; imm = im; use_imm = ui; off = of; last = l;
        in_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        if (!ok) timeout_fail("send_handshake");
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        if (!ok) timeout_fail("wait_idle");
    endtask

    task automatic b_reset_checks(input string tag);
        chk({tag, "_mw"},    32'(mw_b),    32'd0);
        chk({tag, "_wd"},    wd_b,         32'd0);
        chk({tag, "_addr"},  32'(addr_b),  32'd0);
        chk({tag, "_count"}, 32'(count_b), 32'd0);
        chk({tag, "_full"},  32'(full_b),  32'd0);
        chk({tag, "_done"},  32'(done_b),  32'd0);
        chk({tag, "_ill"},   32'(ill_b),   32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        rst_n = 0; in_valid = 0; op = 0; wr = 0; r1 = 0; r2 = 0; imm = 0; use_imm = 0; off = 0; last = 0;
        rst_b = 0; valid_b = 0; op_b = 0; wr_b = 0; r1_b = 0; r2_b = 0; imm_b = 0; use_b = 0; off_b = 0;
        last_b = 0; busy_b = 0;

        chk("enc_add",   enc(8'd2, 3'd3, 3'd1, 3'd2, 8'h00, 1'b0, 8'h00), 32'h02030102);
        chk("enc_beq_r", enc(8'd12, 3'd7, 3'd5, 3'd6, 8'hFF, 1'b1, 8'h10), 32'h0C100506);

        @(negedge clk);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_wdata",     mem_wdata,      32'd0);
        chk("rst_addr",      32'(mem_addr),  32'd0);
        chk("rst_count",     32'(count),     32'd0);
        chk("rst_flags",     32'({illegal, full, done}), 32'd0);
        b_reset_checks("b_rst");
        @(posedge clk); #1;
        rst_n = 1; rst_b = 1; model_on = 1;

        send_a(8'd2, 3'd3, 3'd1, 3'd2, 8'h00, 1'b0, 8'h00, 1'b1);
        wait_idle();
        send_a(8'd0, 3'd4, 3'd0, 3'd0, 8'hA5, 1'b1, 8'h00, 1'b0);
        send_a(8'd7, 3'd0, 3'd1, 3'd2, 8'h00, 1'b0, 8'hFE, 1'b0);
        send_a(8'd6, 3'd0, 3'd0, 3'd0, 8'h00, 1'b0, 8'h03, 1'b1);
        wait_idle();
        chk("log_size", 32'(wlog.size()), 32'd4);
        if (wlog.size() == 4) begin
            chk("w0_addr", 32'(wlog[0].a), 32'd0); chk("w0_data", wlog[0].d, 32'h02030102);
            chk("w1_addr", 32'(wlog[1].a), 32'd0); chk("w1_data", wlog[1].d, 32'h000400A5);
            chk("w2_addr", 32'(wlog[2].a), 32'd4); chk("w2_data", wlog[2].d, 32'h07FE0102);
            chk("w3_addr", 32'(wlog[3].a), 32'd8); chk("w3_data", wlog[3].d, 32'h06030000);
        end

        send_a(8'd200, 3'd1, 3'd1, 3'd1, 8'h11, 1'b1, 8'h22, 1'b1);
        wait_idle();
        repeat (2) @(negedge clk);
        chk("illegal_no_write", 32'(wlog.size()), 32'd4);
        chk("illegal_pulses",   32'(ill_cnt),     32'd1);

        force_busy = 7;
        w0 = wcyc;
        send_a(8'd2, 3'd5, 3'd6, 3'd7, 8'h00, 1'b0, 8'h00, 1'b0);
        wait_idle();
        chk("busy_stall_len", 32'(wcyc - w0 >= 6), 32'd1);

        for (int n = 0; n < 300; n++) begin
            logic [7:0] ro;
            ro = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(21, 255)) : 8'($urandom_range(0, 20));
            send_a(ro, 3'($urandom), 3'($urandom), 3'($urandom), 8'($urandom), 1'($urandom),
                   8'($urandom), ($urandom_range(0, 9) == 0));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        wait_idle();
        repeat (3) @(negedge clk);

        // Small-capacity instance: fill, then ignore, then reset mid-write
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            op_b = 8'd2; wr_b = 3'(k + 1); r1_b = 3'd1; r2_b = 3'd2; use_b = 0; busy_b = 0; valid_b = 1;
            @(posedge clk); #1;
            valid_b = 0;
            chk("b_write_active", 32'(mw_b),   32'd1);
            chk("b_wdata",        wd_b,        (k == 0) ? 32'h02010102 : 32'h02020102);
            chk("b_addr",         32'(addr_b), 32'(k * 4));
            @(posedge clk); #1;
            chk("b_write_done",   32'(mw_b),   32'd0);
        end
        chk("b_full",  32'(full_b),  32'd1);
        chk("b_ready", 32'(ready_b), 32'd0);
        chk("b_count", 32'(count_b), 32'd2);
        chk("b_addr8", 32'(addr_b),  32'd8);
        valid_b = 1;
        repeat (4) begin
            @(posedge clk); #1;
            chk("b_full_ignored", 32'(mw_b), 32'd0);
        end
        chk("b_count_held", 32'(count_b), 32'd2);
        valid_b = 0;

        @(posedge clk); #1; rst_b = 0;
        @(posedge clk); #1; rst_b = 1;
        chk("b_full_cleared",    32'(full_b),  32'd0);
        chk("b_ready_after_rst", 32'(ready_b), 32'd1);
        busy_b = 1; valid_b = 1;
        @(posedge clk); #1;
        valid_b = 0;
        chk("b_midwrite_active", 32'(mw_b), 32'd1);
        #2 rst_b = 0;
        #1 b_reset_checks("b_midrst");
        @(posedge clk); #1;
        rst_b = 1; busy_b = 0;
        #1 chk("b_ready_post", 32'(ready_b), 32'd1);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
